// File: rtl/controle_pkg.sv
// Shared types and constants for the Horner-rule controller of the operativo datapath.
// The optional clear step is enabled by the CONTROLE_CLR_EN macro.
package controle_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADX = 3'd1,
        CLR   = 3'd2,
        MUL1  = 3'd3,
        ADD1  = 3'd4,
        MUL2  = 3'd5,
        ADD2  = 3'd6,
        DONE  = 3'd7
    } state_e;

    // m0: constant mux
    localparam logic [1:0] SEL_ZERO   = 2'd0;
    localparam logic [1:0] SEL_A      = 2'd1;
    localparam logic [1:0] SEL_B      = 2'd2;
    localparam logic [1:0] SEL_C      = 2'd3;

    // m1: ULA operand 1
    localparam logic [1:0] SEL1_OUTM0 = 2'd0;
    localparam logic [1:0] SEL1_X     = 2'd1;
    localparam logic [1:0] SEL1_S     = 2'd2;
    localparam logic [1:0] SEL1_H     = 2'd3;

    // m2: ULA operand 2
    localparam logic [1:0] SEL2_X     = 2'd0;
    localparam logic [1:0] SEL2_OUTM0 = 2'd1;
    localparam logic [1:0] SEL2_S     = 2'd2;
    localparam logic [1:0] SEL2_H     = 2'd3;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef struct packed {
        logic       lx;
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
        logic       h;
        logic       ls;
        logic       lh;
        logic       done;
        logic       busy;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/controle.sv
// Moore controller stepping operativo through S = ((A*X) + B)*X + C.
// Define CONTROLE_CLR_EN to insert a CLR step that zeroes RegS after LOADX.
module controle
    import controle_pkg::*;
(
    input  logic       ck,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       lx,
    output logic [1:0] m0,
    output logic [1:0] m1,
    output logic [1:0] m2,
    output logic       h,
    output logic       ls,
    output logic       lh,
    output logic       done,
    output logic       busy
);

`ifdef CONTROLE_CLR_EN
    localparam state_e AFTER_LOADX = CLR;
`else
    localparam state_e AFTER_LOADX = MUL1;
`endif

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    // Encodings that are not a live state (CLR when the clear step is absent) decode as IDLE.
    function automatic ctrl_t decode(input state_e s);
        ctrl_t c;
        c = CTRL_IDLE;
        case (s)
            LOADX: begin
                c.lx   = 1'b1;
                c.busy = 1'b1;
            end
`ifdef CONTROLE_CLR_EN
            CLR: begin
                c.m0   = SEL_ZERO;
                c.m1   = SEL1_OUTM0;
                c.m2   = SEL2_OUTM0;
                c.h    = OP_ADD;
                c.ls   = 1'b1;
                c.busy = 1'b1;
            end
`endif
            MUL1: begin
                c.m0   = SEL_A;
                c.m1   = SEL1_OUTM0;
                c.m2   = SEL2_X;
                c.h    = OP_MUL;
                c.lh   = 1'b1;
                c.busy = 1'b1;
            end
            ADD1: begin
                c.m0   = SEL_B;
                c.m1   = SEL1_H;
                c.m2   = SEL2_OUTM0;
                c.h    = OP_ADD;
                c.lh   = 1'b1;
                c.busy = 1'b1;
            end
            MUL2: begin
                c.m0   = SEL_ZERO;
                c.m1   = SEL1_H;
                c.m2   = SEL2_X;
                c.h    = OP_MUL;
                c.lh   = 1'b1;
                c.busy = 1'b1;
            end
            ADD2: begin
                c.m0   = SEL_C;
                c.m1   = SEL1_H;
                c.m2   = SEL2_OUTM0;
                c.h    = OP_ADD;
                c.ls   = 1'b1;
                c.busy = 1'b1;
            end
            DONE: begin
                c.done = 1'b1;
                c.busy = 1'b1;
            end
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

    always_comb begin
        // NOTE: default next-state first so every path assigns it and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOADX;
            LOADX:   state_d = abort ? IDLE : AFTER_LOADX;
`ifdef CONTROLE_CLR_EN
            CLR:     state_d = abort ? IDLE : MUL1;
`endif
            MUL1:    state_d = abort ? IDLE : ADD1;
            ADD1:    state_d = abort ? IDLE : MUL2;
            MUL2:    state_d = abort ? IDLE : ADD2;
            ADD2:    state_d = abort ? IDLE : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state, so they stay a pure function of state_q.
        ctrl_d = decode(state_d);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ctrl_q  <= CTRL_IDLE;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign lx   = ctrl_q.lx;
    assign m0   = ctrl_q.m0;
    assign m1   = ctrl_q.m1;
    assign m2   = ctrl_q.m2;
    assign h    = ctrl_q.h;
    assign ls   = ctrl_q.ls;
    assign lh   = ctrl_q.lh;
    assign done = ctrl_q.done;
    assign busy = ctrl_q.busy;

endmodule

// File: tb/tb_controle.sv
// End-to-end bench: controle driving a behavioural 16-bit operativo datapath, checked
// against a polynomial reference. Honours CONTROLE_CLR_EN when defined.
module tb_controle;

`ifdef CONTROLE_CLR_EN
    localparam int LAT    = 7;
    localparam bit CLR_ON = 1'b1;
`else
    localparam int LAT    = 6;
    localparam bit CLR_ON = 1'b0;
`endif
    localparam int ADD1_IDX = CLR_ON ? 3 : 2;
    localparam int MUL2_IDX = ADD1_IDX + 1;

    logic       ck, rst, start, abort;
    logic       lx, h, ls, lh, done, busy;
    logic [1:0] m0, m1, m2;

    controle dut (
        .ck(ck), .rst(rst), .start(start), .abort(abort),
        .lx(lx), .m0(m0), .m1(m1), .m2(m2), .h(h),
        .ls(ls), .lh(lh), .done(done), .busy(busy)
    );

    // Behavioural operativo datapath
    logic [15:0] nx, av, bv, cv;
    logic [15:0] reg_x, reg_h, reg_s;
    logic [15:0] outm0, op1, op2, ula;

    always_comb begin
        case (m0)
            2'd0:    outm0 = 16'h0;
            2'd1:    outm0 = av;
            2'd2:    outm0 = bv;
            default: outm0 = cv;
        endcase
        case (m1)
            2'd0:    op1 = outm0;
            2'd1:    op1 = reg_x;
            2'd2:    op1 = reg_s;
            default: op1 = reg_h;
        endcase
        case (m2)
            2'd0:    op2 = reg_x;
            2'd1:    op2 = outm0;
            2'd2:    op2 = reg_s;
            default: op2 = reg_h;
        endcase
        ula = h ? 16'(op1 * op2) : 16'(op1 + op2);
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            reg_x <= '0;
            reg_h <= '0;
            reg_s <= '0;
        end else begin
            if (lx) reg_x <= nx;
            if (ls) reg_s <= ula;
            if (lh) reg_h <= ula;
        end
    end

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int          checks = 0;
    int          errors = 0;
    logic [15:0] s_model;
    logic [15:0] want_b;
    logic [11:0] rows[$];
    int          dpos[$];
    bit          seen;
    logic [11:0] ctl_vec;

    assign ctl_vec = {busy, done, lx, ls, lh, h, m0, m1, m2};

    function automatic logic [11:0] row(input logic bz, dn, xl, sl, hl, op,
                                        input logic [1:0] s0, s1, s2);
        return {bz, dn, xl, sl, hl, op, s0, s1, s2};
    endfunction

    function automatic logic [15:0] poly(input logic [15:0] x, a, b, c);
        longint unsigned xv, r;
        xv = 64'(x);
        r  = 64'(a) * xv * xv + 64'(b) * xv + 64'(c);
        return r[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
    task automatic run_txn(input logic [15:0] x, a, b, c, input bit full, input string tag);
        logic [15:0] want;
        want = poly(x, a, b, c);
        nx = x; av = a; bv = b; cv = c;
        start = 1'b1;
        @(negedge ck);
        start = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            if (full) begin
                check($sformatf("%s_ctl%0d", tag, i), 32'(ctl_vec), 32'(rows[i]));
                if (i < LAT - 1)
                    check($sformatf("%s_hold%0d", tag, i), 32'(reg_s),
                          32'((CLR_ON && i >= 2) ? 16'h0 : s_model));
            end
            if (i < LAT - 1) @(negedge ck);
        end
        check($sformatf("%s_done", tag), 32'(done), 32'd1);
        check($sformatf("%s_res", tag), 32'(reg_s), 32'(want));
        s_model = want;
        @(negedge ck);
        check($sformatf("%s_idle", tag), 32'(ctl_vec), 32'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        nx = '0; av = '0; bv = '0; cv = '0;
        s_model = '0;

        rows.push_back(row(1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0));   // LOADX
`ifdef CONTROLE_CLR_EN
        rows.push_back(row(1, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd1));   // CLR
`endif
        rows.push_back(row(1, 0, 0, 0, 1, 1, 2'd1, 2'd0, 2'd0));   // MUL1
        rows.push_back(row(1, 0, 0, 0, 1, 0, 2'd2, 2'd3, 2'd1));   // ADD1
        rows.push_back(row(1, 0, 0, 0, 1, 1, 2'd0, 2'd3, 2'd0));   // MUL2
        rows.push_back(row(1, 0, 0, 1, 0, 0, 2'd3, 2'd3, 2'd1));   // ADD2
        rows.push_back(row(1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0));   // DONE

        // Reset state
        @(negedge ck);
        check("rst_ctl", 32'(ctl_vec), 32'd0);
        rst = 1'b1;
        @(negedge ck);
        check("idle_ctl", 32'(ctl_vec), 32'd0);

        // Directed transactions with full per-cycle control checks
        run_txn(16'd3,   16'd2, 16'd5, 16'd7, 1'b1, "t40");
        run_txn(16'd0,   16'd9, 16'd9, 16'd4, 1'b1, "tx0");
        run_txn(16'd300, 16'd1, 16'd0, 16'd0, 1'b1, "twrap");

        // Abort during ADD1
        nx = 16'd11; av = 16'd3; bv = 16'd4; cv = 16'd5;
        start = 1'b1;
        @(negedge ck);
        start = 1'b0;
        for (int i = 0; i < ADD1_IDX; i++) @(negedge ck);
        check("ab_add1", 32'(ctl_vec), 32'(rows[ADD1_IDX]));
        abort = 1'b1;
        @(negedge ck);
        abort = 1'b0;
        check("ab_idle", 32'(ctl_vec), 32'd0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge ck);
            seen |= done;
        end
        check("ab_nodone", 32'(seen), 32'd0);
        s_model = CLR_ON ? 16'h0 : s_model;
        check("ab_hold", 32'(reg_s), 32'(s_model));

        // start and abort together in IDLE: start wins
        nx = 16'd6; av = 16'd7; bv = 16'd8; cv = 16'd9;
        want_b = poly(nx, av, bv, cv);
        start = 1'b1; abort = 1'b1;
        @(negedge ck);
        start = 1'b0; abort = 1'b0;
        check("sa_ctl", 32'(ctl_vec), 32'(rows[0]));
        for (int i = 1; i < LAT; i++) @(negedge ck);
        check("sa_done", 32'(done), 32'd1);
        check("sa_res", 32'(reg_s), 32'(want_b));
        s_model = want_b;
        @(negedge ck);

        // start held high: back-to-back computations
        nx = 16'd3; av = 16'd2; bv = 16'd5; cv = 16'd7;
        want_b = poly(nx, av, bv, cv);
        start = 1'b1;
        for (int c = 1; c <= 3 * (LAT + 1); c++) begin
            @(negedge ck);
            if (done) begin
                dpos.push_back(c);
                check($sformatf("b2b_res%0d", c), 32'(reg_s), 32'(want_b));
            end
        end
        start = 1'b0;
        check("b2b_count", 32'(dpos.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            check($sformatf("b2b_pos%0d", k), 32'((k < dpos.size()) ? dpos[k] : -1),
                  32'(LAT + k * (LAT + 1)));
        s_model = want_b;
        @(negedge ck);
        check("b2b_idle", 32'(ctl_vec), 32'd0);

        // Randomized transactions against the polynomial reference
        for (int n = 0; n < 12; n++)
            run_txn(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0,
                    $sformatf("rnd%0d", n));

        // Asynchronous reset in the middle of MUL2
        nx = 16'd21; av = 16'd22; bv = 16'd23; cv = 16'd24;
        start = 1'b1;
        @(negedge ck);
        start = 1'b0;
        for (int i = 0; i < MUL2_IDX; i++) @(negedge ck);
        check("rs_mul2", 32'(ctl_vec), 32'(rows[MUL2_IDX]));
        #2 rst = 1'b0;
        #1;
        check("rs_async", 32'(ctl_vec), 32'd0);
        @(negedge ck);
        rst = 1'b1;
        @(negedge ck);
        check("rs_idle", 32'(ctl_vec), 32'd0);
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_regs", 32'(reg_s), 32'd0);
        s_model = '0;

        run_txn(16'd3, 16'd2, 16'd5, 16'd7, 1'b1, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
